emif_rst_cal_ctrl: RTL and testbench

EMIF_RST_CAL_CTRL -- requirements
Module: emif_rst_cal_ctrl

---
 rtl/emif_rst_cal_ctrl_pkg.sv | 25 ++
 rtl/emif_cal_tracker.sv | 34 +++
 rtl/emif_rst_cal_ctrl.sv | 110 +++++++++++
 tb/tb_emif_rst_cal_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/emif_rst_cal_ctrl_pkg.sv
// Shared EMIF definitions: controller state encoding and EMIF_STATUS register layout.
package emif_rst_cal_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_ASSERT,
    RST_WAIT_ACK,
    RST_RELEASE,
    CAL_WAIT,
    DONE,
    ERR
  } emif_state_e;

  localparam logic [7:0]  EMIF_STATUS_OFFSET = 8'h08;

  localparam int unsigned STAT_SUCC_LSB    = 0;
  localparam int unsigned STAT_FAIL_LSB    = 16;
  localparam int unsigned STAT_BUSY_BIT    = 32;
  localparam int unsigned STAT_TIMEOUT_BIT = 33;

  function automatic logic is_busy(input emif_state_e s);
    return !(s inside {IDLE, DONE, ERR});
  endfunction

endpackage

// File: rtl/emif_cal_tracker.sv
// Per-channel sticky calibration success/fail latches with resolution summary flags.
module emif_cal_tracker #(
  parameter int unsigned NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [NUM_CH-1:0] cal_success,
  input  logic [NUM_CH-1:0] cal_fail,
  output logic [NUM_CH-1:0] succ_lat,
  output logic [NUM_CH-1:0] fail_lat,
  output logic              all_resolved,
  output logic              any_fail
);

  // Sticky latches: cleared on a new reset sequence, accumulate input levels while enabled.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      succ_lat <= '0;
      fail_lat <= '0;
    end else if (en) begin
      succ_lat <= succ_lat | cal_success;
      fail_lat <= fail_lat | cal_fail;
    end
  end

  // Flags include the current input levels so completion is seen on the sampling edge itself.
  always_comb begin
    all_resolved = &(succ_lat | fail_lat | cal_success | cal_fail);
    any_fail     = |(fail_lat | cal_fail);
  end

endmodule

// File: rtl/emif_rst_cal_ctrl.sv
// EMIF memory-subsystem reset sequencer and calibration monitor with EMIF_STATUS image.
module emif_rst_cal_ctrl
  import emif_rst_cal_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter logic [31:0] CAL_TIMEOUT = 32'd2_000_000,
  parameter int unsigned RST_HOLD    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sw_rst_req,
  output logic              mem_ss_rst_req,
  input  logic              mem_ss_rst_rdy,
  input  logic [NUM_CH-1:0] cal_success,
  input  logic [NUM_CH-1:0] cal_fail,
  output logic [NUM_CH-1:0] afu_mem_rst_n,
  output logic [63:0]       emif_status
);

  emif_state_e       state, state_nxt;
  logic [31:0]       cnt;
  logic              timeout_q;
  logic              timeout_set;
  logic              sw_accept;
  logic [NUM_CH-1:0] succ_lat, fail_lat;
  logic              all_resolved, any_fail;
  logic [63:0]       status_d;
  logic [NUM_CH-1:0] afu_d;

  assign sw_accept      = sw_rst_req && !is_busy(state);
  assign mem_ss_rst_req = (state == RST_ASSERT) || (state == RST_WAIT_ACK);

  emif_cal_tracker #(
    .NUM_CH(NUM_CH)
  ) u_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (sw_accept),
    .en           (state == CAL_WAIT),
    .cal_success  (cal_success),
    .cal_fail     (cal_fail),
    .succ_lat     (succ_lat),
    .fail_lat     (fail_lat),
    .all_resolved (all_resolved),
    .any_fail     (any_fail)
  );

  // Next-state logic; calibration completion outranks the timeout.
  always_comb begin
    state_nxt   = state;
    timeout_set = 1'b0;
    case (state)
      IDLE, DONE, ERR: if (sw_rst_req) state_nxt = RST_ASSERT;
      RST_ASSERT:      if (cnt >= 32'(RST_HOLD - 1)) state_nxt = RST_WAIT_ACK;
      RST_WAIT_ACK:    if (mem_ss_rst_rdy) state_nxt = RST_RELEASE;
      RST_RELEASE:     if (!mem_ss_rst_rdy) state_nxt = CAL_WAIT;
      CAL_WAIT: begin
        if (all_resolved) begin
          state_nxt = any_fail ? ERR : DONE;
        end else if (cnt >= CAL_TIMEOUT - 32'd1) begin
          state_nxt   = ERR;
          timeout_set = 1'b1;
        end
      end
      default:         state_nxt = RST_ASSERT;
    endcase
  end

  // State register; one shared saturating counter, cleared on every state change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RST_ASSERT;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= '0;
      else if (cnt != '1)     cnt <= cnt + 32'd1;
      if (sw_accept)        timeout_q <= 1'b0;
      else if (timeout_set) timeout_q <= 1'b1;
    end
  end

  // Output images built from registered state and latches only.
  always_comb begin
    status_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      status_d[STAT_SUCC_LSB + i] = succ_lat[i];
      status_d[STAT_FAIL_LSB + i] = fail_lat[i];
    end
    status_d[STAT_BUSY_BIT]    = is_busy(state);
    status_d[STAT_TIMEOUT_BIT] = timeout_q;
    afu_d = '0;
    if (state == DONE)     afu_d = '1;
    else if (state == ERR) afu_d = succ_lat & ~fail_lat;
  end

  // Registered outputs; reset value reports busy only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      emif_status   <= '0;
      emif_status[STAT_BUSY_BIT] <= 1'b1;
      afu_mem_rst_n <= '0;
    end else begin
      emif_status   <= status_d;
      afu_mem_rst_n <= afu_d;
    end
  end

endmodule

// File: tb/tb_emif_rst_cal_ctrl.sv
// Self-checking bench for emif_rst_cal_ctrl: directed table, corner sequences, randomized runs.
module tb_emif_rst_cal_ctrl;

  localparam int HOLD = 16;
  localparam int TMO  = 100;

  logic        clk = 1'b0;
  logic        rst_n, sw_rst_req, mem_ss_rst_req, mem_ss_rst_rdy;
  logic [3:0]  cal_success, cal_fail, afu_mem_rst_n;
  logic [63:0] emif_status;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  emif_rst_cal_ctrl #(
    .NUM_CH      (4),
    .CAL_TIMEOUT (32'd100),
    .RST_HOLD    (HOLD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sw_rst_req     (sw_rst_req),
    .mem_ss_rst_req (mem_ss_rst_req),
    .mem_ss_rst_rdy (mem_ss_rst_rdy),
    .cal_success    (cal_success),
    .cal_fail       (cal_fail),
    .afu_mem_rst_n  (afu_mem_rst_n),
    .emif_status    (emif_status)
  );

  typedef struct {
    logic [3:0]  s;
    logic [3:0]  f;
    int          base;
    int          step;
    logic [63:0] exp_status;
    logic [3:0]  exp_afu;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Outcome from the calibration rules: every channel resolved by its last arrival, or timeout.
  function automatic void model(input logic [3:0] s, input logic [3:0] f, input int d[4],
                                output logic [63:0] st, output logic [3:0] afu, output int lat);
    logic timed_out;
    int   tmax;
    timed_out = ((s | f) != 4'hF);
    tmax = 0;
    for (int ch = 0; ch < 4; ch++)
      if ((s[ch] | f[ch]) && d[ch] > tmax) tmax = d[ch];
    lat = timed_out ? TMO + 1 : tmax + 2;
    st = '0;
    st[3:0]   = s;
    st[19:16] = f;
    st[33]    = timed_out;
    afu = (!timed_out && f == 4'h0) ? 4'hF : (s & ~f);
  endfunction

  task automatic sw_pulse();
    sw_rst_req = 1'b1;
    @(posedge clk); #1;
    sw_rst_req = 1'b0;
    check("sw_req_next", 64'(mem_ss_rst_req), 64'd1);
  endtask

  // Drives the reset handshake; returns one cycle before CAL_WAIT entry.
  task automatic run_seq(input bit chk_clear, input bit pulse_again);
    int hi;
    bit fell;
    hi = 1;
    fell = 1'b0;
    cal_success = '0;
    cal_fail    = '0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (k == 1 && chk_clear) begin
        check("clear_afu", 64'(afu_mem_rst_n), 64'd0);
        check("clear_status", emif_status, 64'h1_0000_0000);
      end
      sw_rst_req = pulse_again && (k == 2);
      if (!mem_ss_rst_req) begin
        fell = 1'b1;
        break;
      end
      hi++;
      if (k == 3) mem_ss_rst_rdy = 1'b1;
    end
    sw_rst_req = 1'b0;
    check("req_released", 64'(fell), 64'd1);
    check("req_hold", 64'(hi >= HOLD), 64'd1);
    mem_ss_rst_rdy = 1'b0;
  endtask

  // Applies per-channel levels at their cycle offsets from CAL_WAIT entry; lat = cycles until busy drops.
  task automatic run_cal(input logic [3:0] s, input logic [3:0] f, input int d[4],
                         input int sw_at, output int lat);
    lat = -1;
    for (int c = 0; c <= 150; c++) begin
      @(posedge clk); #1;
      if (!emif_status[32]) begin
        lat = c;
        break;
      end
      sw_rst_req = (c == sw_at);
      for (int ch = 0; ch < 4; ch++)
        if (c == d[ch]) begin
          cal_success[ch] = s[ch];
          cal_fail[ch]    = f[ch];
        end
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic quiet(input int n, input logic [63:0] st_exp, input string name);
    int viol;
    viol = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (mem_ss_rst_req || emif_status !== st_exp) viol++;
    end
    check(name, 64'(viol), 64'd0);
  endtask

  initial begin
    vec_t        vt[5];
    int          d[4];
    int          lat, exp_lat, sw_at, lim;
    logic [63:0] exp_st;
    logic [3:0]  exp_afu, s, f;

    vt[0] = '{4'hF, 4'h0, 10, 0, 64'h0000_0000_0000_000F, 4'hF,    12};
    vt[1] = '{4'hB, 4'h4,  5, 2, 64'h0000_0000_0004_000B, 4'b1011, 13};
    vt[2] = '{4'h0, 4'h0,  0, 0, 64'h0000_0002_0000_0000, 4'h0,   101};
    vt[3] = '{4'hF, 4'h2,  0, 3, 64'h0000_0000_0002_000F, 4'b1101, 11};
    vt[4] = '{4'h7, 4'h0,  2, 1, 64'h0000_0002_0000_0007, 4'b0111, 101};

    rst_n = 1'b0; sw_rst_req = 1'b0; mem_ss_rst_rdy = 1'b0;
    cal_success = '0; cal_fail = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_req", 64'(mem_ss_rst_req), 64'd1);
    check("reset_afu", 64'(afu_mem_rst_n), 64'd0);
    check("reset_status", emif_status, 64'h1_0000_0000);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      if (i > 0) sw_pulse();
      run_seq(1'b1, i == 1);
      d = '{vt[i].base, vt[i].base + vt[i].step, vt[i].base + 2 * vt[i].step, vt[i].base + 3 * vt[i].step};
      run_cal(vt[i].s, vt[i].f, d, -1, lat);
      check($sformatf("vec%0d_status", i), emif_status, vt[i].exp_status);
      check($sformatf("vec%0d_afu", i), 64'(afu_mem_rst_n), 64'(vt[i].exp_afu));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].exp_lat));
      if (i == 1) quiet(20, vt[i].exp_status, "busy_pulse_not_queued");
    end

    // Completion and a software request in the same cycle: completion wins, request dropped.
    sw_pulse();
    run_seq(1'b1, 1'b0);
    d = '{3, 3, 3, 8};
    run_cal(4'hF, 4'h0, d, 8, lat);
    check("same_cycle_latency", 64'(lat), 64'd10);
    check("same_cycle_status", emif_status, 64'hF);
    quiet(30, 64'hF, "same_cycle_no_restart");

    // Reset during calibration with partial success, then a clean sequence.
    sw_pulse();
    run_seq(1'b1, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 1) cal_success = 4'b0011;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_status", emif_status, 64'h1_0000_0000);
    check("midrst_req", 64'(mem_ss_rst_req), 64'd1);
    check("midrst_afu", 64'(afu_mem_rst_n), 64'd0);
    rst_n = 1'b1;
    cal_success = '0;
    run_seq(1'b1, 1'b0);
    d = '{0, 1, 2, 3};
    run_cal(4'hF, 4'h0, d, -1, lat);
    check("post_rst_status", emif_status, 64'hF);
    check("post_rst_latency", 64'(lat), 64'd5);

    // Randomized calibration outcomes against the reference model.
    for (int r = 0; r < 10; r++) begin
      s = 4'($urandom);
      f = 4'($urandom);
      if ($urandom_range(0, 2) != 0) s = s | ~(s | f);
      for (int ch = 0; ch < 4; ch++) d[ch] = $urandom_range(0, 60);
      model(s, f, d, exp_st, exp_afu, exp_lat);
      lim = exp_lat - 2;
      if (lim > TMO - 1) lim = TMO - 1;
      sw_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, lim) : -1;
      sw_pulse();
      run_seq(1'b1, 1'b0);
      run_cal(s, f, d, sw_at, lat);
      check($sformatf("rand%0d_status", r), emif_status, exp_st);
      check($sformatf("rand%0d_afu", r), 64'(afu_mem_rst_n), 64'(exp_afu));
      check($sformatf("rand%0d_latency", r), 64'(lat), 64'(exp_lat));
      quiet(5, exp_st, $sformatf("rand%0d_busy_req_ignored", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
